sys_arr_ctrl: RTL and testbench



---
 rtl/sys_arr_pkg.sv | 24 ++
 rtl/skew_addr_gen.sv | 37 +++
 rtl/sys_arr_ctrl.sv | 137 +++++++++++++
 tb/tb_sys_arr_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared types and default sizing for the systolic-array sequencer, PE grid and RAM mux.
package sys_arr_pkg;

    localparam int DEF_N        = 2;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_MULT_LAT = 1;

    localparam int DLY_DEPTH = DEF_RD_LAT + 2 * (DEF_N - 1) + DEF_MULT_LAT;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } arr_state_t;

    // Wave delay-line depth: RAM latency, worst-case skew to PE(N-1,N-1), multiply latency.
    function automatic int dly_depth(input int n, input int rd_lat, input int mult_lat);
        return rd_lat + 2 * (n - 1) + mult_lat;
    endfunction

endpackage

// File: rtl/skew_addr_gen.sv
// One RAM channel's skewed read window: channel CH reads while CH <= t < CH+k_len.
module skew_addr_gen
    import sys_arr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int T_W    = DEF_ADDR_W + 3,
    parameter int CH     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              feed_i,
    input  logic [T_W-1:0]    t_i,
    input  logic [ADDR_W:0]   k_len_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic              rden_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [T_W-1:0]    rel;
    logic              in_win;
    logic [ADDR_W-1:0] addr_d, addr_q;

    assign rel    = t_i - T_W'(CH);
    assign in_win = feed_i && (t_i >= T_W'(CH)) && (rel < T_W'(k_len_i));

    // Outside the window the port keeps presenting the last address issued.
    assign addr_d = in_win ? (base_i + rel[ADDR_W-1:0]) : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_q <= '0;
        else        addr_q <= addr_d;
    end

    assign rden_o = in_win;
    assign addr_o = addr_d;

endmodule

// File: rtl/sys_arr_ctrl.sv
// Matrix-multiply pass sequencer: skewed A/W RAM reads plus the per-PE enable/clear wave.
module sys_arr_ctrl
    import sys_arr_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         acc_mode_i,
    input  logic                         abort_i,
    input  logic [ADDR_W:0]              k_len_i,
    input  logic [ADDR_W-1:0]            a_base_i,
    input  logic [ADDR_W-1:0]            w_base_i,
    output logic [N-1:0][ADDR_W-1:0]     ram_a_addr_o,
    output logic [N-1:0]                 ram_a_rden_o,
    output logic [N-1:0][ADDR_W-1:0]     ram_w_addr_o,
    output logic [N-1:0]                 ram_w_rden_o,
    output logic                         arr_own_o,
    output logic [N-1:0][N-1:0]          en_mult_o,
    output logic [N-1:0][N-1:0]          clr_mult_o,
    output logic [N-1:0][N-1:0]          en_accum_o,
    output logic [N-1:0][N-1:0]          clr_accum_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int DLY = dly_depth(N, RD_LAT, MULT_LAT);
    localparam int T_W = ADDR_W + $clog2(N) + 2;

    arr_state_t        state_q, state_d;
    logic [ADDR_W:0]   k_q;
    logic [ADDR_W-1:0] a_base_q, w_base_q;
    logic [T_W-1:0]    t_q, t_last;
    logic [DLY-1:0]    dl_q, dl_d;
    logic              accept, kill, feed, wave;

    assign accept = (state_q == IDLE) && start_i && !abort_i;
    assign kill   = abort_i && (state_q != IDLE);
    assign feed   = (state_q == FEED);
    assign t_last = T_W'(k_q) + T_W'(N) - T_W'(2);
    assign wave   = feed && (t_q < T_W'(k_q));

    always_comb begin
        dl_d    = '0;
        dl_d[0] = wave;
        for (int b = 1; b < DLY; b++) dl_d[b] = dl_q[b-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (k_len_i == '0)   state_d = DONE;
                    else if (acc_mode_i) state_d = FEED;
                    else                 state_d = CLEAR;
                end
            end
            CLEAR:   state_d = FEED;
            FEED:    if (t_q == t_last) state_d = DRAIN;
            // Leave on the cycle the last in-flight enable shifts out.
            DRAIN:   if (dl_d == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);
        arr_own_o   = (state_q != IDLE);
        clr_mult_o  = (state_q == CLEAR) ? '1 : '0;
        clr_accum_o = (state_q == CLEAR) ? '1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            a_base_q <= '0;
            w_base_q <= '0;
            t_q      <= '0;
            dl_q     <= '0;
        end else begin
            if (accept) begin
                k_q      <= k_len_i;
                a_base_q <= a_base_i;
                w_base_q <= w_base_i;
                t_q      <= '0;
            end else if (feed) begin
                t_q <= t_q + 1'b1;
            end
            dl_q <= kill ? '0 : dl_d;
        end
    end

    // PE(i,j) sees the wave after the RAM latency plus i+j skew hops.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign en_mult_o[i][j]  = dl_q[RD_LAT + i + j - 1];
            assign en_accum_o[i][j] = dl_q[RD_LAT + i + j + MULT_LAT - 1];
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_ch
        skew_addr_gen #(.ADDR_W(ADDR_W), .T_W(T_W), .CH(c)) u_a (
            .clk     (clk),
            .rst_n   (rst_n),
            .feed_i  (feed),
            .t_i     (t_q),
            .k_len_i (k_q),
            .base_i  (a_base_q),
            .rden_o  (ram_a_rden_o[c]),
            .addr_o  (ram_a_addr_o[c])
        );
        skew_addr_gen #(.ADDR_W(ADDR_W), .T_W(T_W), .CH(c)) u_w (
            .clk     (clk),
            .rst_n   (rst_n),
            .feed_i  (feed),
            .t_i     (t_q),
            .k_len_i (k_q),
            .base_i  (w_base_q),
            .rden_o  (ram_w_rden_o[c]),
            .addr_o  (ram_w_addr_o[c])
        );
    end

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// Bench for sys_arr_ctrl: vector table, randomized jobs vs. a timing model, directed corners.
module tb_sys_arr_ctrl;

    localparam int AW = 8;
    localparam int RD = 1;
    localparam int ML = 1;
    localparam int N2 = 2;
    localparam int N4 = 4;
    localparam int D2 = RD + 2 * (N2 - 1) + ML;
    localparam int VW = 55;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     start = 0, acc_mode = 0, abort = 0;
    logic [AW:0]              k_len = '0;
    logic [AW-1:0]            a_base = '0, w_base = '0;
    logic [N2-1:0][AW-1:0]    a_addr, w_addr;
    logic [N2-1:0]            a_rden, w_rden;
    logic                     own, busy, done;
    logic [N2-1:0][N2-1:0]    em, cm, ea, ca;

    logic                     start4 = 0;
    logic [AW:0]              k_len4 = '0;
    logic [AW-1:0]            a_base4 = '0, w_base4 = '0;
    logic [N4-1:0][AW-1:0]    a_addr4, w_addr4;
    logic [N4-1:0]            a_rden4, w_rden4;
    logic                     own4, busy4, done4;
    logic [N4-1:0][N4-1:0]    em4, cm4, ea4, ca4;

    sys_arr_ctrl #(.N(N2), .ADDR_W(AW), .RD_LAT(RD), .MULT_LAT(ML)) u2 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .acc_mode_i(acc_mode), .abort_i(abort),
        .k_len_i(k_len), .a_base_i(a_base), .w_base_i(w_base),
        .ram_a_addr_o(a_addr), .ram_a_rden_o(a_rden), .ram_w_addr_o(w_addr), .ram_w_rden_o(w_rden),
        .arr_own_o(own), .en_mult_o(em), .clr_mult_o(cm), .en_accum_o(ea), .clr_accum_o(ca),
        .busy_o(busy), .done_o(done)
    );

    sys_arr_ctrl #(.N(N4), .ADDR_W(AW), .RD_LAT(RD), .MULT_LAT(ML)) u4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .acc_mode_i(1'b0), .abort_i(1'b0),
        .k_len_i(k_len4), .a_base_i(a_base4), .w_base_i(w_base4),
        .ram_a_addr_o(a_addr4), .ram_a_rden_o(a_rden4), .ram_w_addr_o(w_addr4), .ram_w_rden_o(w_rden4),
        .arr_own_o(own4), .en_mult_o(em4), .clr_mult_o(cm4), .en_accum_o(ea4), .clr_accum_o(ca4),
        .busy_o(busy4), .done_o(done4)
    );

    int checks = 0;
    int errors = 0;
    logic [N2-1:0][AW-1:0] last_a = '0, last_w = '0;

    typedef struct {
        int         k;
        logic       acc;
        logic [7:0] ab, wb;
        int         rep;
        int         exp_done;
        int         exp_nclr;
        logic [7:0] exp_first, exp_last;
        int         exp_nrd;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs at cycle c after the start sample, straight from the timing rules.
    task automatic model(input int c, input int k, input logic acc, input logic [7:0] ab,
                         input logic [7:0] wb, input logic idle, output logic [VW-1:0] exp);
        logic [N2-1:0] era, erw;
        logic [N2-1:0][N2-1:0] xm, xc, xa;
        logic b_e, d_e;
        int off, dc, tt;
        off = acc ? 1 : 2;
        dc  = off + k + D2;
        tt  = c - off;
        era = '0; erw = '0; xm = '0; xc = '0; xa = '0; b_e = 0; d_e = 0;
        if (!idle) begin
            b_e = (c >= 1) && (c <= dc);
            d_e = (c == dc);
            if (!acc && c == 1) xc = '1;
            for (int i = 0; i < N2; i++) begin
                if (tt >= i && tt < i + k) begin
                    era[i] = 1; erw[i] = 1;
                    last_a[i] = ab + 8'(tt - i);
                    last_w[i] = wb + 8'(tt - i);
                end
                for (int j = 0; j < N2; j++) begin
                    xm[i][j] = (c >= off + RD + i + j) && (c < off + RD + i + j + k);
                    xa[i][j] = (c >= off + RD + i + j + ML) && (c < off + RD + i + j + ML + k);
                end
            end
        end
        exp = {last_a, era, last_w, erw, b_e, xm, xc, xa, xc, b_e, d_e};
    endtask

    task automatic run_job(input int k, input logic acc, input logic [7:0] ab, input logic [7:0] wb,
                           input int abort_at, input int repulse_at,
                           output int done_c, output int ndone, output int nclr,
                           output logic [7:0] a0_first, output logic [7:0] a0_last, output int nrd);
        logic [VW-1:0] exp, act;
        int dc, last;
        done_c = -1; ndone = 0; nclr = 0; nrd = 0; a0_first = '0; a0_last = '0;
        dc   = (acc ? 1 : 2) + k + D2;
        last = (abort_at > 0) ? abort_at + 3 : dc + 2;
        @(posedge clk); #1;
        start = 1; k_len = 9'(k); a_base = ab; w_base = wb; acc_mode = acc;
        @(posedge clk); #1;
        start = 0; k_len = 9'($urandom); a_base = 8'($urandom); w_base = 8'($urandom);
        acc_mode = 1'($urandom);
        for (int c = 1; c <= last; c++) begin
            if (c == repulse_at) start = 1;
            if (c == abort_at) abort = 1;
            @(negedge clk);
            model(c, k, acc, ab, wb, (abort_at > 0) && (c > abort_at), exp);
            act = {a_addr, a_rden, w_addr, w_rden, own, em, cm, ea, ca, busy, done};
            chk($sformatf("cyc%0d_k%0d", c, k), 64'(act), 64'(exp));
            if (done) begin ndone++; done_c = c; end
            if (cm[0][0]) nclr++;
            if (a_rden[0]) begin
                if (nrd == 0) a0_first = a_addr[0];
                a0_last = a_addr[0];
                nrd++;
            end
            @(posedge clk); #1;
            start = 0; abort = 0;
        end
    endtask

    initial begin
        int dc, nd, ncl, nr, cnt, first_c, fc;
        logic [7:0] f, l;

        tbl[0] = '{k:4,   acc:0, ab:8'h10, wb:8'h20, rep:4, exp_done:10,  exp_nclr:1, exp_first:8'h10, exp_last:8'h13, exp_nrd:4};
        tbl[1] = '{k:4,   acc:1, ab:8'h10, wb:8'h20, rep:0, exp_done:9,   exp_nclr:0, exp_first:8'h10, exp_last:8'h13, exp_nrd:4};
        tbl[2] = '{k:4,   acc:0, ab:8'hFE, wb:8'h20, rep:0, exp_done:10,  exp_nclr:1, exp_first:8'hFE, exp_last:8'h01, exp_nrd:4};
        tbl[3] = '{k:1,   acc:0, ab:8'h05, wb:8'h33, rep:0, exp_done:7,   exp_nclr:1, exp_first:8'h05, exp_last:8'h05, exp_nrd:1};
        tbl[4] = '{k:256, acc:1, ab:8'h80, wb:8'h00, rep:0, exp_done:261, exp_nclr:0, exp_first:8'h80, exp_last:8'h7F, exp_nrd:256};

        #12;
        chk("reset_n2", 64'(|{a_addr, a_rden, w_addr, w_rden, own, em, cm, ea, ca, busy, done}), 64'd0);
        chk("reset_n4", 64'(|{a_addr4, a_rden4, w_addr4, w_rden4, own4, em4, cm4, ea4, ca4, busy4, done4}), 64'd0);
        @(negedge clk); rst_n = 1;

        for (int r = 0; r < 5; r++) begin
            run_job(tbl[r].k, tbl[r].acc, tbl[r].ab, tbl[r].wb, 0, tbl[r].rep, dc, nd, ncl, f, l, nr);
            chk($sformatf("tbl%0d_done_cyc", r), 64'(dc), 64'(tbl[r].exp_done));
            chk($sformatf("tbl%0d_ndone", r), 64'(nd), 64'd1);
            chk($sformatf("tbl%0d_nclr", r), 64'(ncl), 64'(tbl[r].exp_nclr));
            chk($sformatf("tbl%0d_a0_first", r), 64'(f), 64'(tbl[r].exp_first));
            chk($sformatf("tbl%0d_a0_last", r), 64'(l), 64'(tbl[r].exp_last));
            chk($sformatf("tbl%0d_nrd", r), 64'(nr), 64'(tbl[r].exp_nrd));
        end

        // Abort mid-feed, then a fresh job must run normally.
        run_job(4, 0, 8'h10, 8'h20, 5, 0, dc, nd, ncl, f, l, nr);
        chk("abort_ndone", 64'(nd), 64'd0);
        run_job(4, 0, 8'h10, 8'h20, 0, 0, dc, nd, ncl, f, l, nr);
        chk("after_abort_done_cyc", 64'(dc), 64'd10);

        // Abort and start together in IDLE: nothing starts.
        @(posedge clk); #1;
        start = 1; abort = 1; k_len = 9'd4;
        @(posedge clk); #1;
        start = 0; abort = 0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cnt += int'(busy) + int'(own) + int'(|a_rden) + int'(|cm);
        end
        chk("abort_wins_idle", 64'(cnt), 64'd0);

        // k_len = 0: straight to a single done pulse, nothing else moves.
        @(posedge clk); #1;
        start = 1; k_len = '0; acc_mode = 0; a_base = 8'h44;
        @(posedge clk); #1;
        start = 0;
        cnt = 0; nd = 0; dc = -1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cnt += int'(|{a_rden, w_rden, em, ea, cm, ca});
            if (done) begin nd++; dc = c; end
        end
        chk("k0_no_activity", 64'(cnt), 64'd0);
        chk("k0_ndone", 64'(nd), 64'd1);
        chk("k0_done_early", 64'(dc >= 1 && dc <= 2), 64'd1);

        // Randomized jobs against the model.
        for (int r = 0; r < 12; r++) begin
            int kk, rp;
            logic aa;
            logic [7:0] b0, b1;
            kk = int'($urandom_range(1, 12));
            aa = 1'($urandom_range(0, 1));
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
            run_job(kk, aa, b0, b1, 0, rp, dc, nd, ncl, f, l, nr);
            chk($sformatf("rnd%0d_done_cyc", r), 64'(dc), 64'((aa ? 1 : 2) + kk + D2));
            chk($sformatf("rnd%0d_ndone", r), 64'(nd), 64'd1);
        end

        // N=4, k_len=1: far-corner PE timing.
        @(posedge clk); #1;
        start4 = 1; k_len4 = 9'd1; a_base4 = 8'h30; w_base4 = 8'h40;
        @(posedge clk); #1;
        start4 = 0; k_len4 = 9'd7;
        cnt = 0; first_c = -1; dc = -1; nr = 0; fc = -1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (em4[3][3]) begin cnt++; if (first_c < 0) first_c = c; end
            if (done4) dc = c;
            if (a_rden4[3]) begin nr++; fc = c; end
        end
        chk("n4_em33_cycle", 64'(first_c), 64'd9);
        chk("n4_em33_count", 64'(cnt), 64'd1);
        chk("n4_done_cycle", 64'(dc), 64'd11);
        chk("n4_rden3_cycle", 64'(fc), 64'd5);
        chk("n4_rden3_count", 64'(nr), 64'd1);

        // Async reset in the middle of a job.
        @(posedge clk); #1;
        start = 1; k_len = 9'd4; a_base = 8'h10; w_base = 8'h20; acc_mode = 0;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_rst_n2", 64'(|{a_addr, a_rden, w_addr, w_rden, own, em, cm, ea, ca, busy, done}), 64'd0);
        @(negedge clk); rst_n = 1;
        last_a = '0; last_w = '0;
        @(negedge clk);
        chk("after_rst_idle", 64'({busy, own}), 64'd0);
        run_job(2, 0, 8'h07, 8'h09, 0, 0, dc, nd, ncl, f, l, nr);
        chk("after_rst_done_cyc", 64'(dc), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
